// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared widths, port indices and request record for the
//            data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;

    // Requester slots: 0 is the CPU load/store unit, 1 is the debug/loader.
    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    // One access as presented by a requester.
    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Bundles both requester handshakes and the memory-side bus.
//            slave = arbiter view, master = environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter with one-hot combinational grant.
//            Grants are forced off while reset is asserted.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [1:0] req,
    output logic      [1:0] gnt
);

    // Index of the port that wins a tie on the next contended cycle.
    logic r_prio_ptr;

    // Grant the lone requester, or the favoured one under contention.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req[PORT_CPU] && req[PORT_DBG]) begin
                gnt = r_prio_ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // After any grant, favour the port that was not served; idle keeps it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio_ptr <= 1'b0;
        end else if (gnt[PORT_CPU]) begin
            r_prio_ptr <= 1'b1;
        end else if (gnt[PORT_DBG]) begin
            r_prio_ptr <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port data memory between the CPU and a debug
//            master. Routes the granted access to memory and returns read
//            data one cycle later with a single-cycle valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    dmem_arbiter_if.slave   bus
);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    dmem_req_t         w_req_cpu;
    dmem_req_t         w_req_dbg;
    dmem_req_t         w_sel;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_rd_cpu;
    logic              w_rd_dbg;

    logic              r_m0_rvalid;
    logic [DATA_W-1:0] r_m0_rdata;
    logic              r_m1_rvalid;
    logic [DATA_W-1:0] r_m1_rdata;

    assign w_req = {bus.m1_req, bus.m0_req};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (w_req),
        .gnt   (w_gnt)
    );

    assign w_req_cpu = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
    assign w_req_dbg = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};

    // Port 0 drives the bus unless port 1 holds the grant (idle shows port 0).
    assign w_sel       = w_gnt[PORT_DBG] ? w_req_dbg : w_req_cpu;
    assign w_mem_addr  = w_sel.addr;
    assign w_mem_wdata = w_sel.wdata;

    assign bus.mem_we    = w_sel.we & (|w_gnt);
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    assign bus.m0_gnt = w_gnt[PORT_CPU];
    assign bus.m1_gnt = w_gnt[PORT_DBG];

    assign w_rd_cpu = w_gnt[PORT_CPU] & ~bus.m0_we;
    assign w_rd_dbg = w_gnt[PORT_DBG] & ~bus.m1_we;

    // Capture read data for the granted reader; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_rd_cpu;
            r_m1_rvalid <= w_rd_dbg;
            if (w_rd_cpu) begin
                r_m0_rdata <= bus.mem_rdata;
            end
            if (w_rd_dbg) begin
                r_m1_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.m0_rvalid = r_m0_rvalid;
    assign bus.m0_rdata  = r_m0_rdata;
    assign bus.m1_rvalid = r_m1_rvalid;
    assign bus.m1_rdata  = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: directed scenarios then
//            protocol-respecting random traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory attached to the arbiter: synchronous write, combinational read.
    logic [3:0] mem [16] = '{default: 4'h0};
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // Reference model state.
    logic [3:0] ref_mem [16] = '{default: 4'h0};
    logic       ref_ptr = 1'b0;
    logic       ref_rv0 = 1'b0;
    logic       ref_rv1 = 1'b0;
    logic [3:0] ref_rd0 = 4'h0;
    logic [3:0] ref_rd1 = 4'h0;
    logic [1:0] last_g  = 2'b00;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arbitration rule: nothing in reset; a lone requester wins; ties go to ptr.
    function automatic logic [1:0] exp_gnt(input logic rn, input logic r0,
                                           input logic r1, input logic p);
        if (!rn) return 2'b00;
        if (r0 && r1) return p ? 2'b10 : 2'b01;
        return {r1, r0};
    endfunction

    task automatic set_in(input logic r0, input logic w0, input logic [3:0] a0, input logic [3:0] d0,
                          input logic r1, input logic w1, input logic [3:0] a1, input logic [3:0] d1);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
    endtask

    // One clock cycle: check outputs mid-cycle, optionally assert reset just
    // before the edge, then advance the model across the edge.
    task automatic step(input bit drop_rst = 1'b0);
        logic [1:0] g;
        logic       e_we;
        #1;
        g = exp_gnt(rst_n, bus.m0_req, bus.m1_req, ref_ptr);
        e_we = g[0] ? bus.m0_we : (g[1] ? bus.m1_we : 1'b0);
        chk("m0_gnt", 32'(bus.m0_gnt), 32'(g[0]));
        chk("m1_gnt", 32'(bus.m1_gnt), 32'(g[1]));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        if (g[0]) begin
            chk("mem_addr_p0", 32'(bus.mem_addr), 32'(bus.m0_addr));
            if (bus.m0_we) chk("mem_wdata_p0", 32'(bus.mem_wdata), 32'(bus.m0_wdata));
        end else if (g[1]) begin
            chk("mem_addr_p1", 32'(bus.mem_addr), 32'(bus.m1_addr));
            if (bus.m1_we) chk("mem_wdata_p1", 32'(bus.mem_wdata), 32'(bus.m1_wdata));
        end
        chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(ref_rv0));
        chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(ref_rv1));
        chk("m0_rdata", 32'(bus.m0_rdata), 32'(ref_rd0));
        chk("m1_rdata", 32'(bus.m1_rdata), 32'(ref_rd1));
        if (drop_rst) rst_n = 1'b0;
        @(posedge clk);
        g = exp_gnt(rst_n, bus.m0_req, bus.m1_req, ref_ptr);
        last_g = g;
        if (!rst_n) begin
            ref_ptr = 1'b0;
            ref_rv0 = 1'b0; ref_rv1 = 1'b0;
            ref_rd0 = 4'h0; ref_rd1 = 4'h0;
        end else begin
            ref_rv0 = g[0] && !bus.m0_we;
            ref_rv1 = g[1] && !bus.m1_we;
            if (ref_rv0) ref_rd0 = ref_mem[bus.m0_addr];
            if (ref_rv1) ref_rd1 = ref_mem[bus.m1_addr];
            if (g[0] && bus.m0_we) ref_mem[bus.m0_addr] = bus.m0_wdata;
            if (g[1] && bus.m1_we) ref_mem[bus.m1_addr] = bus.m1_wdata;
            if (g != 2'b00) ref_ptr = g[0];
        end
        @(negedge clk);
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);

        // Reset held with a pending port-0 write: nothing may reach memory.
        set_in(1'b1, 1'b1, 4'd3, 4'd9, 1'b0, 1'b0, 4'h0, 4'h0);
        step(); step();
        chk("mem3_during_reset", 32'(mem[3]), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mem3_after_release", 32'(mem[3]), 32'd9);

        // Port 1 loads mem[1]=7, then port 0 reads it back.
        set_in(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'd1, 4'd7);
        step();
        set_in(1'b1, 1'b0, 4'd1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        step();
        idle(); step(); step();

        // Contended reads of mem[0]=3 and mem[2]=10 over four cycles.
        set_in(1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 4'h0, 4'h0); step();
        set_in(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'd2, 4'd10); step();
        set_in(1'b1, 1'b0, 4'd0, 4'h0, 1'b1, 1'b0, 4'd2, 4'h0);
        repeat (4) step();
        idle(); step(); step();

        // Write by port 1 immediately followed by a read of the same word.
        set_in(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'd5, 4'hC); step();
        set_in(1'b1, 1'b0, 4'd5, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0); step();
        idle(); step();
        chk("hazard_rdata", 32'(bus.m0_rdata), 32'hC);

        // Port 1 alone, then both: port 0 must be served first.
        set_in(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'd2, 4'h0); step();
        set_in(1'b1, 1'b0, 4'd1, 4'h0, 1'b1, 1'b0, 4'd2, 4'h0); step(); step();
        idle(); step();

        // Reset lands on the edge ending a port-0 read grant.
        set_in(1'b1, 1'b0, 4'd1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        step(1'b1);
        rst_n = 1'b1;
        idle(); step();
        set_in(1'b1, 1'b0, 4'd0, 4'h0, 1'b1, 1'b0, 4'd2, 4'h0);
        chk("ptr_after_reset_gnt0", 32'(exp_gnt(1'b1, 1'b1, 1'b1, ref_ptr)), 32'b01);
        step(); step();
        idle(); step();

        // Random traffic; a pending (ungranted) request is held unchanged.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            if (!(bus.m0_req && !last_g[0])) begin
                bus.m0_req   = ($urandom_range(0, 2) != 0);
                bus.m0_we    = 1'($urandom_range(0, 1));
                bus.m0_addr  = 4'($urandom_range(0, 15));
                bus.m0_wdata = 4'($urandom_range(0, 15));
            end
            if (!(bus.m1_req && !last_g[1])) begin
                bus.m1_req   = ($urandom_range(0, 2) != 0);
                bus.m1_we    = 1'($urandom_range(0, 1));
                bus.m1_addr  = 4'($urandom_range(0, 15));
                bus.m1_wdata = 4'($urandom_range(0, 15));
            end
            step();
        end
        rst_n = 1'b1;
        idle(); step();

        for (int a = 0; a < 16; a++) begin
            chk($sformatf("mem[%0d]", a), 32'(mem[a]), 32'(ref_mem[a]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
